dm_latency_ctrl: RTL
====================

DM_LATENCY_CTRL -- requirements
Module: dm_latency_ctrl

Interface
REQ-001 Parameter DATA_W, default 32, data width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 16, word-address width.
REQ-003 Parameter DEPTH, default 4096, number of implemented words; SHALL satisfy DEPTH <= 2**ADDR_W.
REQ-004 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..7.
REQ-005 clk  input  1  single clock; all state changes on the rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  block can accept a request.
REQ-009 req_write  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 req_wstrb  input  DATA_W/8  byte write enables; bit i covers bits [8i+7:8i].
REQ-013 rsp_valid  output  1  response present.
REQ-014 rsp_ready  input  1  consumer accepts the response.
REQ-015 rsp_rdata  output  DATA_W  read data.
REQ-016 rsp_err  output  1  out-of-range address flag.

Function
REQ-017 The block SHALL contain DEPTH x DATA_W storage and SHALL have exactly one outstanding request at a time.
REQ-018 The FSM SHALL have three states: IDLE, WAIT, RESP.
REQ-019 In IDLE: req_ready = 1 and rsp_valid = 0. In WAIT and RESP: req_ready = 0.
REQ-020 Acceptance SHALL occur on a rising edge where state = IDLE and req_valid = 1.
REQ-021 On acceptance with req_addr < DEPTH and req_write = 1, each byte with req_wstrb[i] = 1 SHALL be written at that edge.
REQ-022 Bytes with req_wstrb[i] = 0 SHALL be left unchanged; req_wstrb = 0 SHALL perform no write and still produce a response.
REQ-023 On acceptance of a read with req_addr < DEPTH, the word SHALL be captured at that edge into a response register.
REQ-024 For a write, the response register SHALL capture 0.
REQ-025 On acceptance with req_addr >= DEPTH: no storage change; captured rdata = 0; captured err = 1. Otherwise captured err = 0.
REQ-026 On acceptance with LATENCY = 1, the next state SHALL be RESP.
REQ-027 On acceptance with LATENCY > 1, the next state SHALL be WAIT and a down-counter SHALL be loaded with LATENCY-2.
REQ-028 In WAIT: if counter = 0, go to RESP; else decrement the counter.
REQ-029 rsp_valid SHALL rise exactly LATENCY cycles after the acceptance edge.
REQ-030 In RESP: rsp_valid = 1, and rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready = 1.
REQ-031 That rsp_ready = 1 edge SHALL return the FSM to IDLE.
REQ-032 No new request SHALL be accepted on the same edge as a response handshake.
REQ-033 req_valid arriving while not in IDLE SHALL be ignored: no storage change, no state change.
REQ-034 rsp_ready while not in RESP SHALL have no effect.
REQ-035 Outside RESP, rsp_rdata and rsp_err SHALL hold their last captured values; they carry meaning only while rsp_valid = 1.

Reset
REQ-036 While rst_n = 0: state = IDLE, counter = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, all taking effect immediately without a clock edge.
REQ-037 Reset SHALL NOT clear the storage array.
REQ-038 Reset asserted in WAIT or RESP SHALL abandon the pending response; a write already performed at acceptance SHALL remain in storage.

Verification
REQ-039 LATENCY=2: write addr 5, wdata 0xDEADBEEF, wstrb 0xF; then read addr 5 -> read rsp_valid 2 cycles after acceptance, rdata 0xDEADBEEF, err 0.
REQ-040 Preload addr 5 = 0xDEADBEEF; write addr 5, wdata 0x11223344, wstrb 0x5; then read addr 5 -> rdata 0xDE22BE44.
REQ-041 Read addr DEPTH (4096) -> rsp_err 1, rdata 0; a following write at 4096 -> rsp_err 1 and no storage word changes.
REQ-042 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready 0, and a req_valid pulse is ignored; then rsp_ready 1 -> IDLE and req_ready 1 next cycle.
REQ-043 LATENCY=1 and LATENCY=7 builds -> rsp_valid exactly 1 and 7 cycles after acceptance; with rsp_ready tied 1, throughput is one request per LATENCY+1 cycles.
REQ-044 Assert rst_n = 0 mid-WAIT after a write of 0xCAFEF00D to addr 9 -> rsp_valid 0 and req_ready 1 immediately; a subsequent read of addr 9 returns 0xCAFEF00D.

Source files
------------

// File: rtl/dm_latency_ctrl.sv
// Byte-strobed word memory behind a request/response handshake with a fixed,
// parameterised response latency and a single outstanding request.
module dm_latency_ctrl #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DEPTH   = 4096,
  parameter int unsigned LATENCY = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  // Reject illegal parameter sets at elaboration
  if ((DATA_W % 8 != 0) || (LATENCY < 1) || (LATENCY > 7) ||
      (64'(DEPTH) > (64'(1) << ADDR_W))) begin : g_bad_param
    $error("dm_latency_ctrl: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic               accept;
  logic               in_range;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  wmask;

  assign accept   = (state == IDLE) && req_valid;
  assign in_range = {1'b0, req_addr} < (ADDR_W + 1)'(DEPTH);
  assign idx      = req_addr[IDX_W-1:0];

  // Expand byte strobes into a bit mask
  always_comb begin
    wmask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      wmask[8*i +: 8] = {8{req_wstrb[i]}};
    end
  end

  // Storage is intentionally not reset; a write lands on the acceptance edge
  always_ff @(posedge clk) begin
    if (accept && in_range && req_write) begin
      mem[idx] <= (mem[idx] & ~wmask) | (req_wdata & wmask);
    end
  end

  // Control FSM; handshake outputs are registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            rsp_rdata <= (in_range && !req_write) ? mem[idx] : '0;
            rsp_err   <= !in_range;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
